// File: rtl/swerv_types.sv
// Shared types and constants for the EXU multiply pipeline.
//   MUL_DATA_W     : default operand/result width
//   MUL_TAG_W      : default (and maximum) result tag width
//   mul_pipe_pkt_t : multiply control packet carried through stage 1
package swerv_types;

  localparam int unsigned MUL_DATA_W = 32;
  localparam int unsigned MUL_TAG_W  = 5;

  typedef struct packed {
    logic                 valid;
    logic                 rs1_sign;
    logic                 rs2_sign;
    logic                 low;
    logic                 ld_byp_a;
    logic                 ld_byp_b;
    logic [MUL_TAG_W-1:0] tag;
  } mul_pipe_pkt_t;

endpackage

// File: rtl/exu_mul_stage.sv
// One valid+payload pipeline register of the multiply pipe.
//   clk, rst_l : clock, asynchronous active-low reset (valid and data clear)
//   scan_mode  : forces the data enable so the data flops see clocks in scan
//   freeze     : hold valid and data
//   flush      : clear valid on the next edge (data untouched)
//   vld_in/din : incoming valid and payload
//   vld_out/dout : registered valid and payload
module exu_mul_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         scan_mode,
  input  logic         freeze,
  input  logic         flush,
  input  logic         vld_in,
  input  logic [W-1:0] din,
  output logic         vld_out,
  output logic [W-1:0] dout
);

  logic data_en;

  // Data only moves with a valid operation so idle cycles do not toggle the
  // wide payload flops.
  assign data_en = ~freeze & (vld_in | scan_mode);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_out <= 1'b0;
    end else if (flush) begin
      vld_out <= 1'b0;
    end else if (!freeze) begin
      vld_out <= vld_in;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dout <= '0;
    end else if (data_en) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/exu_mul_pipe.sv
// EXU pipelined multiplier: MUL/MULH/MULHSU/MULHU on DATA_W operands with a
// pass-through tag, freeze, flush and a stage-1 load-data bypass.
// Latency in_valid -> out_valid is STAGES-1 cycles, or STAGES cycles when the
// macro RV_MUL_OUT_REG_EN adds a registered output.
//   clk, rst_l        : clock, asynchronous active-low reset
//   scan_mode         : scan mode, forces data-register enables
//   freeze, flush     : hold all stages / kill in-flight work
//   in_valid, a, b    : issue and operands
//   rs1_sign, rs2_sign: operand signedness
//   low               : select low (1) or high (0) half of the product
//   ld_byp_a/b, lsu_result : replace the captured operand in stage 1
//   in_tag            : tag carried with the operation
//   out_valid, out, out_tag : result
//   busy              : any stage holds a valid operation
// TAG_W must not exceed swerv_types::MUL_TAG_W.
module exu_mul_pipe import swerv_types::*; #(
  parameter int unsigned DATA_W = MUL_DATA_W,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = MUL_TAG_W
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scan_mode,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              rs1_sign,
  input  logic              rs2_sign,
  input  logic              low,
  input  logic              ld_byp_a,
  input  logic              ld_byp_b,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] lsu_result,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int unsigned S1_W = 2*DATA_W + 5 + TAG_W;
  localparam int unsigned S2_W = 2*DATA_W + 3 + TAG_W;
  localparam int unsigned PR_W = 2*DATA_W + 1 + TAG_W;
  localparam int unsigned NP   = (STAGES > 3) ? STAGES - 3 : 0;

  // ---------------- stage 1: operand capture ----------------
  logic              s1_vld;
  logic [S1_W-1:0]   s1_q;
  logic [DATA_W-1:0] s1_a, s1_b, a1, b1;
  logic [TAG_W-1:0]  s1_tag;
  mul_pipe_pkt_t     s1_pkt;
  logic signed [DATA_W:0] s1_ax, s1_bx;

  // A frozen stage 1 still honours flush; an unfrozen one simply loads
  // in_valid, which both kills the old op and accepts a same-cycle issue.
  exu_mul_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_l     (rst_l),
    .scan_mode (scan_mode),
    .freeze    (freeze),
    .flush     (flush & freeze),
    .vld_in    (in_valid),
    .din       ({a, b, rs1_sign, rs2_sign, low, ld_byp_a, ld_byp_b, in_tag}),
    .vld_out   (s1_vld),
    .dout      (s1_q)
  );

  always_comb begin
    s1_pkt = '0;
    {s1_a, s1_b, s1_pkt.rs1_sign, s1_pkt.rs2_sign, s1_pkt.low,
     s1_pkt.ld_byp_a, s1_pkt.ld_byp_b, s1_tag} = s1_q;
    s1_pkt.valid = s1_vld;
    s1_pkt.tag   = MUL_TAG_W'(s1_tag);
  end

  assign a1    = s1_pkt.ld_byp_a ? lsu_result : s1_a;
  assign b1    = s1_pkt.ld_byp_b ? lsu_result : s1_b;
  assign s1_ax = {s1_pkt.rs1_sign & a1[DATA_W-1], a1};
  assign s1_bx = {s1_pkt.rs2_sign & b1[DATA_W-1], b1};

  // ---------------- stage 2: extended operands ----------------
  logic                   s2_vld;
  logic signed [DATA_W:0] s2_ax, s2_bx;
  logic                   s2_low;
  logic [TAG_W-1:0]       s2_tag;

  // With STAGES=2 only one register fits before the output, so stage 2
  // collapses into wires and the multiplier runs straight off stage 1.
  if (STAGES >= 3) begin : g_s2
    logic [S2_W-1:0] s2_q;

    exu_mul_stage #(.W(S2_W)) u_s2 (
      .clk       (clk),
      .rst_l     (rst_l),
      .scan_mode (scan_mode),
      .freeze    (freeze),
      .flush     (flush),
      .vld_in    (s1_pkt.valid),
      .din       ({s1_ax, s1_bx, s1_pkt.low, TAG_W'(s1_pkt.tag)}),
      .vld_out   (s2_vld),
      .dout      (s2_q)
    );

    assign {s2_ax, s2_bx, s2_low, s2_tag} = s2_q;
  end else begin : g_s2_wire
    assign s2_vld = s1_pkt.valid;
    assign s2_ax  = s1_ax;
    assign s2_bx  = s1_bx;
    assign s2_low = s1_pkt.low;
    assign s2_tag = TAG_W'(s1_pkt.tag);
  end

  // ---------------- multiplier + retiming registers ----------------
  logic signed [2*DATA_W-1:0] ax_w, bx_w, p;

  // Only the low 2*DATA_W product bits are kept, so the sign-extended
  // operands need no more width than that.
  assign ax_w = {{(DATA_W-1){s2_ax[DATA_W]}}, s2_ax};
  assign bx_w = {{(DATA_W-1){s2_bx[DATA_W]}}, s2_bx};
  assign p    = ax_w * bx_w;

  logic [NP:0]            pr_vld;
  logic [NP:0][PR_W-1:0]  pr_q;

  assign pr_vld[0] = s2_vld;
  assign pr_q[0]   = {p, s2_low, s2_tag};

  for (genvar i = 0; i < NP; i++) begin : g_pr
    exu_mul_stage #(.W(PR_W)) u_pr (
      .clk       (clk),
      .rst_l     (rst_l),
      .scan_mode (scan_mode),
      .freeze    (freeze),
      .flush     (flush),
      .vld_in    (pr_vld[i]),
      .din       (pr_q[i]),
      .vld_out   (pr_vld[i+1]),
      .dout      (pr_q[i+1])
    );
  end

  logic [2*DATA_W-1:0] fin_p;
  logic                fin_low;
  logic [TAG_W-1:0]    fin_tag;
  logic [DATA_W-1:0]   res;

  assign {fin_p, fin_low, fin_tag} = pr_q[NP];
  assign res = fin_low ? fin_p[DATA_W-1:0] : fin_p[2*DATA_W-1:DATA_W];

  // ---------------- output ----------------
`ifdef RV_MUL_OUT_REG_EN
  logic [DATA_W+TAG_W-1:0] o_q;

  exu_mul_stage #(.W(DATA_W+TAG_W)) u_out (
    .clk       (clk),
    .rst_l     (rst_l),
    .scan_mode (scan_mode),
    .freeze    (freeze),
    .flush     (flush),
    .vld_in    (pr_vld[NP]),
    .din       ({res, fin_tag}),
    .vld_out   (out_valid),
    .dout      (o_q)
  );

  assign {out, out_tag} = o_q;
  assign busy = s1_vld | (|pr_vld) | out_valid;
`else
  assign out_valid = pr_vld[NP];
  assign out       = res;
  assign out_tag   = fin_tag;
  assign busy      = s1_vld | (|pr_vld);
`endif

endmodule

// File: tb/tb_exu_mul_pipe.sv
// Self-checking bench for exu_mul_pipe. Expected results go into a
// scoreboard queue at issue and are compared when out_valid retires.
module tb_exu_mul_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
);

`ifdef RV_MUL_OUT_REG_EN
  localparam int unsigned LAT = STAGES;
`else
  localparam int unsigned LAT = STAGES - 1;
`endif

  logic              clk = 1'b0;
  logic              rst_l, scan_mode, freeze, flush, in_valid;
  logic              rs1_sign, rs2_sign, low, ld_byp_a, ld_byp_b;
  logic [DATA_W-1:0] a, b, lsu_result;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid, busy;
  logic [DATA_W-1:0] out;
  logic [TAG_W-1:0]  out_tag;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  exu_mul_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .scan_mode  (scan_mode),
    .freeze     (freeze),
    .flush      (flush),
    .in_valid   (in_valid),
    .rs1_sign   (rs1_sign),
    .rs2_sign   (rs2_sign),
    .low        (low),
    .ld_byp_a   (ld_byp_a),
    .ld_byp_b   (ld_byp_b),
    .a          (a),
    .b          (b),
    .lsu_result (lsu_result),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out        (out),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_mul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                                input logic sx, input logic sy, input logic lo);
    logic [129:0] xe, ye, pr;
    xe = '0;
    ye = '0;
    xe[DATA_W-1:0] = x;
    ye[DATA_W-1:0] = y;
    if (sx && x[DATA_W-1]) xe[129:DATA_W] = '1;
    if (sy && y[DATA_W-1]) ye[129:DATA_W] = '1;
    pr = xe * ye;
    return lo ? pr[DATA_W-1:0] : pr[2*DATA_W-1:DATA_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    freeze   = 1'b0;
    ld_byp_a = 1'b0;
    ld_byp_b = 1'b0;
  endtask

  task automatic drive(input logic [DATA_W-1:0] ia, input logic [DATA_W-1:0] ib,
                       input logic s1, input logic s2, input logic lo,
                       input logic ba, input logic bb, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    rs1_sign = s1;
    rs2_sign = s2;
    low      = lo;
    ld_byp_a = ba;
    ld_byp_b = bb;
    in_tag   = t;
  endtask

  task automatic push(input logic [DATA_W-1:0] r, input logic [TAG_W-1:0] t);
    exp_t e;
    e.res = r;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic rand_op(input logic [TAG_W-1:0] t);
    logic [DATA_W-1:0] ra, rb;
    logic s1, s2, lo;
    ra = DATA_W'({$urandom, $urandom});
    rb = DATA_W'({$urandom, $urandom});
    s1 = 1'($urandom_range(1, 0));
    s2 = 1'($urandom_range(1, 0));
    lo = 1'($urandom_range(1, 0));
    drive(ra, rb, s1, s2, lo, 1'b0, 1'b0, t);
    push(ref_mul(ra, rb, s1, s2, lo), t);
  endtask

  // Retirement monitor: a result leaves the pipe on an unfrozen cycle.
  always @(negedge clk) begin
    if (rst_l && out_valid && !freeze) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out", out, e.res);
        chk("out_tag", out_tag, e.tag);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] ones, two, neg_msb, lo_exp;
    ones    = '1;
    two     = DATA_W'(2);
    neg_msb = {1'b1, {(DATA_W-1){1'b0}}};
    lo_exp  = ones & ~DATA_W'(1);

    rst_l = 1'b0; scan_mode = 1'b0;
    idle();
    a = '0; b = '0; lsu_result = '0; in_tag = '0;
    rs1_sign = 1'b0; rs2_sign = 1'b0; low = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, '0);
    chk("rst_out_tag", out_tag, '0);
    chk("rst_busy", busy, 1'b0);
    rst_l = 1'b1;
    step();

    // MULH -1 * 2: latency and tag
    drive(ones, two, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, TAG_W'(7));
    push(ones, TAG_W'(7));
    step();
    idle();
    repeat (LAT - 2) step();
    chk("lat_early", out_valid, 1'b0);
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_tag", out_tag, TAG_W'(7));
    step();

    // MUL low half, MULHU, MULHSU
    drive(ones, two, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, TAG_W'(8));
    push(lo_exp, TAG_W'(8));
    step();
    drive(ones, ones, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TAG_W'(9));
    push(lo_exp, TAG_W'(9));
    step();
    drive(neg_msb, ones, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, TAG_W'(10));
    push(neg_msb, TAG_W'(10));
    step();
    idle();
    repeat (LAT + 2) step();

    // back-to-back, tags 1..4, results on consecutive cycles
    for (int unsigned k = 0; k <= LAT + 4; k++) begin
      idle();
      if (k < 4) rand_op(TAG_W'(k + 1));
      chk($sformatf("b2b_valid_%0d", k), out_valid, (k >= LAT && k < LAT + 4));
      step();
    end

    // freeze cycles 1-3 with a dropped issue in cycle 2
    for (int unsigned k = 0; k <= LAT + 5; k++) begin
      idle();
      if (k == 0) begin
        drive(DATA_W'(6), DATA_W'(7), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TAG_W'(5));
        push(DATA_W'(42), TAG_W'(5));
      end
      if (k >= 1 && k <= 3) freeze = 1'b1;
      if (k == 2) drive(DATA_W'(9), DATA_W'(9), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TAG_W'(6));
      chk($sformatf("frz_valid_%0d", k), out_valid, (k == LAT + 3));
      step();
    end

    // flush with a same-cycle issue: only the new op survives
    for (int unsigned k = 0; k <= LAT + 3; k++) begin
      idle();
      if (k == 0) drive(DATA_W'(3), DATA_W'(3), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TAG_W'(1));
      if (k == 1) begin
        flush = 1'b1;
        drive(DATA_W'(4), DATA_W'(5), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TAG_W'(2));
        push(DATA_W'(20), TAG_W'(2));
      end
      chk($sformatf("fl_valid_%0d", k), out_valid, (k == LAT + 1));
      if (k == LAT + 1) chk("fl_busy_hi", busy, 1'b1);
      if (k == LAT + 2) chk("fl_busy_lo", busy, 1'b0);
      step();
    end

    // flush during freeze wins
    idle();
    drive(DATA_W'(2), DATA_W'(2), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TAG_W'(3));
    step();
    idle();
    freeze = 1'b1;
    flush  = 1'b1;
    step();
    idle();
    chk("frzfl_busy", busy, 1'b0);
    repeat (LAT + 1) step();

    // stage-1 load bypass on a, then on b
    lsu_result = DATA_W'(3);
    drive(DATA_W'($urandom), DATA_W'(5), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, TAG_W'(11));
    push(DATA_W'(15), TAG_W'(11));
    step();
    drive(DATA_W'(7), DATA_W'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, TAG_W'(12));
    push(DATA_W'(21), TAG_W'(12));
    step();
    idle();
    repeat (LAT + 2) step();

    // random mix
    for (int unsigned k = 0; k < 8; k++) begin
      rand_op(TAG_W'(16 + k));
      step();
    end
    idle();
    repeat (LAT + 2) step();

    // reset while a result sits at the output and another is in flight
    drive(DATA_W'(11), DATA_W'(13), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TAG_W'(13));
    step();
    drive(DATA_W'(17), DATA_W'(19), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TAG_W'(14));
    step();
    idle();
    repeat (LAT - 2) step();
    chk("rst_pre_valid", out_valid, 1'b1);
    rst_l = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 1'b0);
    chk("rstmid_out", out, '0);
    chk("rstmid_out_tag", out_tag, '0);
    chk("rstmid_busy", busy, 1'b0);
    step();
    step();
    rst_l = 1'b1;
    for (int unsigned k = 0; k < LAT + 2; k++) begin
      chk($sformatf("rstpost_valid_%0d", k), out_valid, 1'b0);
      step();
    end

    // pipe still works after reset
    drive(DATA_W'(12), DATA_W'(12), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, TAG_W'(15));
    push(DATA_W'(144), TAG_W'(15));
    step();
    idle();
    repeat (LAT + 2) step();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
